// File: rtl/avalon_st_capture_pkg.sv
// Shared types for the Avalon-ST capture block: FSM states, record layout, error bit indices.
package avalon_st_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam int ERR_SOP_IN_PKT   = 0;
  localparam int ERR_NO_SOP       = 1;
  localparam int ERR_EMPTY_NO_EOP = 2;

  localparam int DEF_TS_W    = 32;
  localparam int DEF_EMPTY_W = 3;
  localparam int DEF_DATA_W  = 64;

  // Record layout at the default widths; the top packs the same field order for any widths.
  typedef struct packed {
    logic [DEF_TS_W-1:0]    ts;
    logic                   sop;
    logic                   eop;
    logic [DEF_EMPTY_W-1:0] empty;
    logic [DEF_DATA_W-1:0]  data;
  } cap_rec_t;

  // EOP closes the packet even when SOP arrives on the same beat.
  function automatic logic next_in_pkt(input logic in_pkt, input logic sop, input logic eop);
    if (eop) return 1'b0;
    if (sop) return 1'b1;
    return in_pkt;
  endfunction

endpackage

// File: rtl/avalon_st_capture_ram.sv
// Simple dual-port capture memory: one write port, one registered read port, no reset.
module avalon_st_capture_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // Read of an address written in the same cycle returns the previous content.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/avalon_st_capture.sv
// Avalon-ST sink recording accepted beats with a cycle timestamp into on-chip memory.
// Capture runs from arm to first SOP until stop/full, with packet counting and sticky framing errors.
module avalon_st_capture #(
  parameter int DATA_W        = 64,
  parameter int EMPTY_W       = 3,
  parameter int DEPTH         = 1024,
  parameter int TS_W          = 32,
  parameter int STALL_ON_FULL = 0
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              valid,
  output logic                              ready,
  input  logic                              startofpacket,
  input  logic                              endofpacket,
  input  logic [DATA_W-1:0]                 data,
  input  logic [EMPTY_W-1:0]                empty,
  input  logic                              arm,
  input  logic                              stop_req,
  input  logic                              rd_en,
  input  logic [$clog2(DEPTH)-1:0]          rd_addr,
  output logic                              rd_valid,
  output logic [TS_W+2+EMPTY_W+DATA_W-1:0]  rd_data,
  output logic [$clog2(DEPTH):0]            wr_count,
  output logic [31:0]                       pkt_count,
  output logic                              busy,
  output logic                              done,
  output logic                              full,
  output logic                              overflow,
  output logic [2:0]                        err
);
  import avalon_st_capture_pkg::*;

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int REC_W = TS_W + 2 + EMPTY_W + DATA_W;

  state_t            r_state;
  logic [CW-1:0]     r_wr_count;
  logic [31:0]       r_pkt_count;
  logic [TS_W-1:0]   r_ts;
  logic              r_in_pkt;
  logic              r_overflow;
  logic              r_rd_valid;
  logic [2:0]        r_err;

  logic              w_acc;
  logic              w_we;
  logic              w_full;
  logic              w_last;
  logic              w_in_pkt_nx;
  logic              w_chk;
  logic [2:0]        w_err_set;
  logic [REC_W-1:0]  w_wdata;
  logic [REC_W-1:0]  w_rdata;

  assign w_full      = (r_wr_count == CW'(DEPTH));
  assign w_last      = (r_wr_count == CW'(DEPTH - 1));
  assign ready       = !((STALL_ON_FULL != 0) && (r_state == ST_DONE) && w_full);
  assign w_acc       = valid & ready;
  assign w_in_pkt_nx = w_acc ? next_in_pkt(r_in_pkt, startofpacket, endofpacket) : r_in_pkt;
  assign w_chk       = w_acc && !arm && (r_state != ST_IDLE);
  assign w_wdata     = {r_ts, startofpacket, endofpacket, empty, data};

  always_comb begin
    w_we = 1'b0;
    if (w_acc && !arm) begin
      case (r_state)
        ST_ARMED:            w_we = startofpacket;
        ST_CAPTURE, ST_DRAIN: w_we = 1'b1;
        default:             w_we = 1'b0;
      endcase
    end
  end

  // Non-SOP beats while waiting for the first packet are silently skipped.
  always_comb begin
    w_err_set = '0;
    if (w_chk) begin
      w_err_set[ERR_SOP_IN_PKT]   = startofpacket & r_in_pkt;
      w_err_set[ERR_NO_SOP]       = !startofpacket & !r_in_pkt & (r_state != ST_ARMED);
      w_err_set[ERR_EMPTY_NO_EOP] = (empty != '0) & !endofpacket;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_wr_count  <= '0;
      r_pkt_count <= '0;
      r_ts        <= '0;
      r_in_pkt    <= 1'b0;
      r_overflow  <= 1'b0;
      r_err       <= '0;
    end else if (arm) begin
      r_state     <= ST_ARMED;
      r_wr_count  <= '0;
      r_pkt_count <= '0;
      r_ts        <= '0;
      r_in_pkt    <= 1'b0;
      r_overflow  <= 1'b0;
      r_err       <= '0;
    end else begin
      r_ts     <= r_ts + 1'b1;
      r_in_pkt <= w_in_pkt_nx;
      r_err    <= r_err | w_err_set;
      if (w_we) begin
        r_wr_count <= r_wr_count + 1'b1;
        if (endofpacket) r_pkt_count <= r_pkt_count + 32'd1;
      end
      if ((r_state == ST_DONE) && w_acc && w_full) r_overflow <= 1'b1;
      case (r_state)
        ST_ARMED:
          if (w_we) r_state <= ST_CAPTURE;
        ST_CAPTURE:
          if (w_we && w_last)  r_state <= ST_DONE;
          else if (stop_req)   r_state <= w_in_pkt_nx ? ST_DRAIN : ST_DONE;
        ST_DRAIN:
          if (w_we && (endofpacket || w_last)) r_state <= ST_DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rd_valid <= 1'b0;
    else          r_rd_valid <= rd_en;
  end

  avalon_st_capture_ram #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_wr_count[AW-1:0]),
    .i_wdata (w_wdata),
    .i_re    (rd_en),
    .i_raddr (rd_addr),
    .o_rdata (w_rdata)
  );

  // The RAM has no reset, so the output is held at zero until a read completes.
  assign rd_data   = r_rd_valid ? w_rdata : '0;
  assign rd_valid  = r_rd_valid;
  assign wr_count  = r_wr_count;
  assign pkt_count = r_pkt_count;
  assign busy      = (r_state == ST_ARMED) || (r_state == ST_CAPTURE) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign err       = r_err;

endmodule

// File: tb/tb_avalon_st_capture.sv
// Scoreboarded bench for avalon_st_capture: behavioural capture model, read-record queue, negedge monitor.
`timescale 1ns/1ps
module tb_avalon_st_capture;
  import avalon_st_capture_pkg::*;

  localparam int DW = 64, EW = 3, DEP = 8, TW = 32, AW = 3;
  localparam int RW = TW + 2 + EW + DW;
  localparam int P_IDLE = 0, P_SEEK = 1, P_CAP = 2, P_DRAIN = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic valid = 1'b0, sop = 1'b0, eop = 1'b0, arm = 1'b0, stop_req = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] data = '0;
  logic [EW-1:0] empty = '0;
  logic [AW-1:0] rd_addr = '0;

  logic rdy0, rv0, busy0, done0, full0, ovf0;
  logic [RW-1:0] rdd0;
  logic [AW:0] wc0;
  logic [31:0] pc0;
  logic [2:0] err0;
  logic rdy1, rv1, busy1, done1, full1, ovf1;
  logic [RW-1:0] rdd1;
  logic [AW:0] wc1;
  logic [31:0] pc1;
  logic [2:0] err1;

  int n_checks = 0;
  int n_fail = 0;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] m_mem[DEP];
  int m_phase, m_wr, m_pkt;
  bit m_inpkt, m_ovf;
  bit [2:0] m_err;
  bit [TW-1:0] m_ts;

  cap_rec_t rec0, rec2;

  always #5 clk = ~clk;

  avalon_st_capture #(.DATA_W(DW), .EMPTY_W(EW), .DEPTH(DEP), .TS_W(TW), .STALL_ON_FULL(0)) u0 (
    .clk(clk), .reset_n(reset_n), .valid(valid), .ready(rdy0), .startofpacket(sop),
    .endofpacket(eop), .data(data), .empty(empty), .arm(arm), .stop_req(stop_req),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv0), .rd_data(rdd0), .wr_count(wc0),
    .pkt_count(pc0), .busy(busy0), .done(done0), .full(full0), .overflow(ovf0), .err(err0));

  avalon_st_capture #(.DATA_W(DW), .EMPTY_W(EW), .DEPTH(DEP), .TS_W(TW), .STALL_ON_FULL(1)) u1 (
    .clk(clk), .reset_n(reset_n), .valid(valid), .ready(rdy1), .startofpacket(sop),
    .endofpacket(eop), .data(data), .empty(empty), .arm(arm), .stop_req(stop_req),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rv1), .rd_data(rdd1), .wr_count(wc1),
    .pkt_count(pc1), .busy(busy1), .done(done1), .full(full1), .overflow(ovf1), .err(err1));

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    m_phase = P_IDLE; m_wr = 0; m_pkt = 0; m_inpkt = 0; m_ovf = 0; m_err = 0; m_ts = 0;
  endtask

  // Capture rules applied to one clock edge; the DUT under model never stalls.
  task automatic model_edge(input bit v, input bit s, input bit e, input int emp,
                            input logic [DW-1:0] d, input bit a, input bit stp);
    bit wr;
    if (a) begin
      m_phase = P_SEEK; m_wr = 0; m_pkt = 0; m_inpkt = 0; m_ovf = 0; m_err = 0; m_ts = 0;
      return;
    end
    wr = 0;
    if (v) begin
      wr = (m_phase == P_SEEK && s) || m_phase == P_CAP || m_phase == P_DRAIN;
      if (m_phase != P_IDLE) begin
        if (s && m_inpkt) m_err[0] = 1;
        if (!s && !m_inpkt && m_phase != P_SEEK) m_err[1] = 1;
        if (emp != 0 && !e) m_err[2] = 1;
      end
      if (m_phase == P_DONE && m_wr == DEP) m_ovf = 1;
      if (wr) begin
        m_mem[m_wr] = {m_ts, s, e, emp[EW-1:0], d};
        m_wr++;
        if (e) m_pkt++;
      end
      m_inpkt = e ? 1'b0 : (s ? 1'b1 : m_inpkt);
    end
    if (m_phase == P_SEEK) begin
      if (wr) m_phase = P_CAP;
    end else if (m_phase == P_CAP) begin
      if (wr && m_wr == DEP) m_phase = P_DONE;
      else if (stp) m_phase = m_inpkt ? P_DRAIN : P_DONE;
    end else if (m_phase == P_DRAIN) begin
      if (wr && (e || m_wr == DEP)) m_phase = P_DONE;
    end
    m_ts = m_ts + 1;
  endtask

  task automatic tick(input bit v, input bit s, input bit e, input int emp, input logic [DW-1:0] d,
                      input bit a, input bit stp, input bit re, input int ra);
    valid = v; sop = s; eop = e; empty = emp[EW-1:0]; data = d;
    arm = a; stop_req = stp; rd_en = re; rd_addr = ra[AW-1:0];
    if (re) exp_q.push_back(m_mem[ra]);
    model_edge(v, s, e, emp, d, a, stp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();                   tick(0, 0, 0, 0, '0, 0, 0, 0, 0); endtask
  task automatic do_arm();                 tick(0, 0, 0, 0, '0, 1, 0, 0, 0); endtask
  task automatic rd(input int a);          tick(0, 0, 0, 0, '0, 0, 0, 1, a); endtask
  task automatic beat(input bit s, input bit e, input int emp, input logic [DW-1:0] d);
    tick(1, s, e, emp, d, 0, 0, 0, 0);
  endtask

  task automatic status(input string tag);
    chk({tag, "/wr_count"}, wc0, m_wr);
    chk({tag, "/pkt_count"}, pc0, m_pkt);
    chk({tag, "/busy"}, busy0, (m_phase >= P_SEEK && m_phase <= P_DRAIN));
    chk({tag, "/done"}, done0, m_phase == P_DONE);
    chk({tag, "/full"}, full0, m_wr == DEP);
    chk({tag, "/overflow"}, ovf0, m_ovf);
    chk({tag, "/err"}, err0, m_err);
    chk({tag, "/ready"}, rdy0, 1);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "/ready0"}, rdy0, 1);      chk({tag, "/ready1"}, rdy1, 1);
    chk({tag, "/rd_valid"}, rv0, 0);     chk({tag, "/rd_data"}, rdd0, 0);
    chk({tag, "/wr_count0"}, wc0, 0);    chk({tag, "/wr_count1"}, wc1, 0);
    chk({tag, "/pkt_count"}, pc0, 0);    chk({tag, "/busy"}, busy0, 0);
    chk({tag, "/done"}, done0, 0);       chk({tag, "/full"}, full0, 0);
    chk({tag, "/overflow"}, ovf0, 0);    chk({tag, "/err"}, err0, 0);
  endtask

  // Scoreboard monitor: every read response is matched against the record queued when it was issued.
  always @(negedge clk) begin
    if (reset_n && rv0) begin
      chk("rd_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) chk("rd_record", rdd0, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v, s, e, stp, re;
    int emp, ra;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    reset_n = 1'b1;

    // Beat in IDLE is discarded.
    beat(1, 1, 0, 64'h99);
    status("idle");

    // Three-beat packet.
    do_arm();
    beat(1, 0, 0, 64'd1);
    beat(0, 0, 0, 64'd2);
    beat(0, 1, 5, 64'd3);
    idle();
    status("pkt3");
    chk("pkt3/wr_const", wc0, 3);
    chk("pkt3/pkt_const", pc0, 1);
    rd(0);
    rec0 = rdd0;
    rd(2);
    rec2 = rdd0;
    idle();
    chk("pkt3/e2_sop", rec2.sop, 0);
    chk("pkt3/e2_eop", rec2.eop, 1);
    chk("pkt3/e2_empty", rec2.empty, 5);
    chk("pkt3/e2_data", rec2.data, 3);
    chk("pkt3/ts_delta", rec2.ts - rec0.ts, 2);

    // Leading non-SOP beats are skipped without error.
    do_arm();
    beat(0, 0, 0, 64'd10);
    beat(0, 0, 0, 64'd11);
    beat(1, 0, 0, 64'd12);
    beat(0, 1, 0, 64'd13);
    idle();
    status("skip");
    chk("skip/wr_const", wc0, 2);
    rd(0);
    rd(1);
    idle();

    // Ten single-beat packets into an eight-entry memory.
    do_arm();
    for (int i = 1; i <= 10; i++) begin
      beat(1, 1, 0, 64'(i));
      chk($sformatf("stall/ready_%0d", i), rdy1, (i >= 8) ? 0 : 1);
      if (i == 8) status("full_edge");
    end
    status("overflow");
    chk("overflow/ovf_const", ovf0, 1);
    chk("stall/wr_count", wc1, 8);
    chk("stall/overflow", ovf1, 0);
    chk("stall/done", done1, 1);
    chk("stall/full", full1, 1);
    rd(7);
    idle();

    // Stop request mid-packet drains to the EOP.
    do_arm();
    beat(1, 0, 0, 64'h20);
    tick(1, 0, 0, 0, 64'h21, 0, 1, 0, 0);
    chk("stop/busy_drain", busy0, 1);
    beat(0, 0, 0, 64'h22);
    beat(0, 1, 0, 64'h23);
    chk("stop/done_after_eop", done0, 1);
    beat(1, 1, 0, 64'h24);
    status("stop");
    chk("stop/wr_const", wc0, 4);
    for (int i = 0; i < 4; i++) rd(i);
    idle();

    // Framing errors accumulate and clear on arm.
    do_arm();
    beat(1, 0, 0, 64'h30);
    beat(1, 0, 0, 64'h31);
    beat(0, 1, 0, 64'h32);
    chk("frame/err_a", err0, 3'b001);
    beat(0, 1, 0, 64'h33);
    chk("frame/err_b", err0, 3'b011);
    beat(0, 0, 2, 64'h34);
    chk("frame/err_c", err0, 3'b111);
    status("frame");
    do_arm();
    chk("frame/err_clear", err0, 3'b000);

    // Randomized traffic against the model.
    for (int r = 0; r < 4; r++) begin
      do_arm();
      for (int c = 0; c < 25; c++) begin
        v   = ($urandom_range(0, 3) != 0);
        s   = ($urandom_range(0, 2) == 0);
        e   = ($urandom_range(0, 2) == 0);
        emp = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 0;
        stp = ($urandom_range(0, 29) == 0);
        re  = (m_wr > 0) && ($urandom_range(0, 2) == 0);
        ra  = re ? int'($urandom_range(0, m_wr - 1)) : 0;
        tick(v, s, e, emp, {$urandom, $urandom}, 0, stp, re, ra);
      end
      idle();
      status($sformatf("rand%0d", r));
    end

    // Asynchronous reset mid-capture, then a clean capture.
    do_arm();
    beat(1, 0, 0, 64'h50);
    beat(0, 0, 0, 64'h51);
    reset_n = 1'b0;
    #1;
    reset_checks("async_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    m_reset();
    do_arm();
    beat(1, 0, 0, 64'h40);
    beat(0, 1, 0, 64'h41);
    idle();
    status("post_rst");
    rd(0);
    rd(1);
    idle();
    idle();
    chk("rd_queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
